// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: serves init, CMD17 block reads and CMD24 block writes from on-chip memory.
// Latency: one Ncr 0xFF byte after the command CRC byte, then R1; backdoor reads return data one clk later.
// Backpressure: none; the initiator owns sclk and the card reacts per byte, cs high aborts any operation.
module sd_spi_responder #(
    parameter int BLK_ADDR_W   = 4,
    parameter int ACMD41_POLLS = 2,
    parameter int READ_GAP     = 2,
    parameter int BUSY_BYTES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  mem_we,
    input  logic [BLK_ADDR_W+8:0] mem_addr,
    input  logic [7:0]            mem_wdata,
    output logic [7:0]            mem_rdata,
    output logic                  card_idle,
    output logic                  busy
);

    localparam int AW    = BLK_ADDR_W + 9;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = (ACMD41_POLLS < 1) ? 1 : $clog2(ACMD41_POLLS + 1);
    localparam logic [CW-1:0] POLLS_C   = CW'(ACMD41_POLLS);
    localparam logic [9:0]    GAP_LAST  = 10'(READ_GAP - 1);
    localparam logic [9:0]    BUSY_LAST = 10'(BUSY_BYTES - 1);

    typedef enum logic [3:0] {
        WAIT_CMD, CMD_RX, RESP_GAP, RESP_TX,
        RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
        WR_WAIT_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
    } state_t;

    typedef enum logic [1:0] {ACT_NONE, ACT_RD, ACT_WR} act_t;

    // synchronizers and edge detection
    logic [1:0] cs_sync, sclk_sync, mosi_sync;
    logic       sclk_q;
    logic       cs_s, sclk_rise, sclk_fall;

    // byte engine
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic       byte_done;
    logic [7:0] tx_shift;
    logic [7:0] tx_load;

    // memory side
    logic [7:0]    mem [0:DEPTH-1];
    logic [7:0]    spi_rdata;
    logic [AW-1:0] spi_addr;
    logic          spi_we;

    // protocol state
    state_t        state, state_nxt;
    logic [9:0]    cnt, cnt_nxt;
    logic [5:0]    cmd_idx, cmd_nxt;
    logic [31:0]   arg, arg_nxt;
    logic [39:0]   resp, resp_nxt;
    logic          resp_long, long_nxt;
    act_t          act, act_nxt;
    logic          idle_nxt;
    logic [CW-1:0] acmd_cnt, acmd_nxt;
    logic          app_flag, app_nxt;
    logic [7:0]    tx_byte, tx_nxt;

    // command decode results
    logic [7:0]    dec_r1;
    logic          dec_long;
    logic [31:0]   dec_trail;
    act_t          dec_act;
    logic          dec_idle;
    logic [CW-1:0] dec_acmd;
    logic          dec_app;
    logic          arg_oob;

    assign cs_s      = cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign miso      = cs_s | tx_shift[7];
    assign tx_load   = (state == RD_DATA) ? spi_rdata : tx_byte;
    assign spi_addr  = {arg[BLK_ADDR_W-1:0], cnt[8:0]};
    assign arg_oob   = |arg[31:BLK_ADDR_W];

    // bring the SPI pins into the clk domain; cs idles deselected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b11;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_q    <= sclk_sync[1];
        end
    end

    // sample mosi on sclk rise, shift miso on sclk fall; a new TX byte loads on the fall after a full byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            byte_done <= 1'b0;
            tx_shift  <= 8'hFF;
        end else begin
            byte_done <= 1'b0;
            if (cs_s) begin
                bit_cnt  <= 3'd0;
                tx_shift <= 8'hFF;
            end else if (sclk_rise) begin
                rx_shift  <= {rx_shift[6:0], mosi_sync[1]};
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= (bit_cnt == 3'd7);
            end else if (sclk_fall) begin
                if (bit_cnt == 3'd0) begin
                    tx_shift <= tx_load;
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b1};
                end
            end
        end
    end

    // block memory writes; the SPI write is applied last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (spi_we) begin
            mem[spi_addr] <= rx_shift;
        end
    end

    // registered read ports; both return the contents from before any same-cycle write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= 8'h00;
            spi_rdata <= 8'h00;
        end else begin
            mem_rdata <= mem[mem_addr];
            spi_rdata <= mem[spi_addr];
        end
    end

    // protocol state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_CMD;
            cnt       <= 10'd0;
            cmd_idx   <= 6'd0;
            arg       <= 32'h0;
            resp      <= 40'h0;
            resp_long <= 1'b0;
            act       <= ACT_NONE;
            card_idle <= 1'b1;
            acmd_cnt  <= '0;
            app_flag  <= 1'b0;
            tx_byte   <= 8'hFF;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cmd_idx   <= cmd_nxt;
            arg       <= arg_nxt;
            resp      <= resp_nxt;
            resp_long <= long_nxt;
            act       <= act_nxt;
            card_idle <= idle_nxt;
            acmd_cnt  <= acmd_nxt;
            app_flag  <= app_nxt;
            tx_byte   <= tx_nxt;
        end
    end

    // decode the received command into R1, trailing bytes, data action and card-state updates
    always_comb begin
        dec_r1    = 8'h04 | {7'b0, card_idle};
        dec_long  = 1'b0;
        dec_trail = 32'h0;
        dec_act   = ACT_NONE;
        dec_idle  = card_idle;
        dec_acmd  = acmd_cnt;
        dec_app   = 1'b0;
        case (cmd_idx)
            6'd0: begin
                dec_r1   = 8'h01;
                dec_idle = 1'b1;
                dec_acmd = '0;
            end
            6'd8: begin
                dec_r1    = {7'b0, card_idle};
                dec_long  = 1'b1;
                dec_trail = {16'h0000, 8'h01, arg[7:0]};
            end
            6'd16: dec_r1 = {7'b0, card_idle};
            6'd55: begin
                dec_r1  = {7'b0, card_idle};
                dec_app = 1'b1;
            end
            6'd41: begin
                if (app_flag) begin
                    if (acmd_cnt < POLLS_C) begin
                        dec_r1   = 8'h01;
                        dec_acmd = acmd_cnt + CW'(1);
                    end else begin
                        dec_r1   = 8'h00;
                        dec_idle = 1'b0;
                    end
                end
            end
            6'd58: begin
                dec_r1    = {7'b0, card_idle};
                dec_long  = 1'b1;
                dec_trail = 32'hC0FF_8000;
            end
            6'd17, 6'd24: begin
                if (card_idle) begin
                    dec_r1 = 8'h05;
                end else if (arg_oob) begin
                    dec_r1 = 8'h40;
                end else begin
                    dec_r1  = 8'h00;
                    dec_act = (cmd_idx == 6'd17) ? ACT_RD : ACT_WR;
                end
            end
            default: ;
        endcase
    end

    // byte-level sequencing: each completed byte slot chooses what the card sends in the next slot
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cmd_nxt   = cmd_idx;
        arg_nxt   = arg;
        resp_nxt  = resp;
        long_nxt  = resp_long;
        act_nxt   = act;
        idle_nxt  = card_idle;
        acmd_nxt  = acmd_cnt;
        app_nxt   = app_flag;
        tx_nxt    = tx_byte;
        spi_we    = 1'b0;
        if (cs_s) begin
            state_nxt = WAIT_CMD;
            cnt_nxt   = 10'd0;
            tx_nxt    = 8'hFF;
        end else if (byte_done) begin
            case (state)
                WAIT_CMD: begin
                    if (rx_shift[7:6] == 2'b01) begin
                        cmd_nxt   = rx_shift[5:0];
                        cnt_nxt   = 10'd1;
                        state_nxt = CMD_RX;
                    end
                end
                CMD_RX: begin
                    if (cnt == 10'd5) begin
                        // CRC byte just finished: latch the response, next slot is Ncr
                        resp_nxt  = {dec_r1, dec_trail};
                        long_nxt  = dec_long;
                        act_nxt   = dec_act;
                        idle_nxt  = dec_idle;
                        acmd_nxt  = dec_acmd;
                        app_nxt   = dec_app;
                        tx_nxt    = 8'hFF;
                        state_nxt = RESP_GAP;
                    end else begin
                        arg_nxt = {arg[23:0], rx_shift};
                        cnt_nxt = cnt + 10'd1;
                    end
                end
                RESP_GAP: begin
                    tx_nxt    = resp[39:32];
                    cnt_nxt   = 10'd0;
                    state_nxt = RESP_TX;
                end
                RESP_TX: begin
                    if (resp_long && cnt < 10'd4) begin
                        tx_nxt   = resp[31:24];
                        resp_nxt = {resp[31:0], 8'h00};
                        cnt_nxt  = cnt + 10'd1;
                    end else begin
                        cnt_nxt = 10'd0;
                        tx_nxt  = 8'hFF;
                        case (act)
                            ACT_RD: begin
                                if (READ_GAP == 0) begin
                                    tx_nxt    = 8'hFE;
                                    state_nxt = RD_TOKEN;
                                end else begin
                                    state_nxt = RD_GAP;
                                end
                            end
                            ACT_WR:  state_nxt = WR_WAIT_TOKEN;
                            default: state_nxt = WAIT_CMD;
                        endcase
                    end
                end
                RD_GAP: begin
                    if (cnt == GAP_LAST) begin
                        tx_nxt    = 8'hFE;
                        state_nxt = RD_TOKEN;
                    end else begin
                        cnt_nxt = cnt + 10'd1;
                    end
                end
                RD_TOKEN: begin
                    cnt_nxt   = 10'd0;
                    state_nxt = RD_DATA;
                end
                RD_DATA: begin
                    if (cnt == 10'd511) begin
                        cnt_nxt   = 10'd0;
                        tx_nxt    = 8'hFF;
                        state_nxt = RD_CRC;
                    end else begin
                        cnt_nxt = cnt + 10'd1;
                    end
                end
                RD_CRC: begin
                    if (cnt == 10'd1) begin
                        cnt_nxt   = 10'd0;
                        state_nxt = WAIT_CMD;
                    end else begin
                        cnt_nxt = cnt + 10'd1;
                    end
                end
                WR_WAIT_TOKEN: begin
                    if (rx_shift == 8'hFE) begin
                        cnt_nxt   = 10'd0;
                        state_nxt = WR_DATA;
                    end else if (rx_shift != 8'hFF) begin
                        state_nxt = WAIT_CMD;
                    end
                end
                WR_DATA: begin
                    spi_we = 1'b1;
                    if (cnt == 10'd511) begin
                        cnt_nxt   = 10'd0;
                        state_nxt = WR_CRC;
                    end else begin
                        cnt_nxt = cnt + 10'd1;
                    end
                end
                WR_CRC: begin
                    if (cnt == 10'd1) begin
                        cnt_nxt   = 10'd0;
                        tx_nxt    = 8'h05;
                        state_nxt = WR_RESP;
                    end else begin
                        cnt_nxt = cnt + 10'd1;
                    end
                end
                WR_RESP: begin
                    cnt_nxt = 10'd0;
                    if (BUSY_BYTES == 0) begin
                        tx_nxt    = 8'hFF;
                        state_nxt = WAIT_CMD;
                    end else begin
                        tx_nxt    = 8'h00;
                        state_nxt = WR_BUSY;
                    end
                end
                WR_BUSY: begin
                    if (cnt == BUSY_LAST) begin
                        cnt_nxt   = 10'd0;
                        tx_nxt    = 8'hFF;
                        state_nxt = WAIT_CMD;
                    end else begin
                        cnt_nxt = cnt + 10'd1;
                        tx_nxt  = 8'h00;
                    end
                end
                default: state_nxt = WAIT_CMD;
            endcase
        end
    end

    // busy covers the R1 of an accepted read/write through its final CRC or busy byte
    always_comb begin
        busy = 1'b0;
        case (state)
            RESP_TX: busy = (act != ACT_NONE);
            RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
            WR_WAIT_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule
